// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg: AutoConfig register offsets (as A[6:1]), ER_TYPE field constants, chain FSM states
package autoconfig_pkg;
    localparam int IDX_W = 3;
    localparam logic [7:0] ER_BOARD_PAGE = 8'hE8;
    localparam logic [5:0] ERO_TYPE     = 6'h00;
    localparam logic [5:0] ERO_PROD     = 6'h02;
    localparam logic [5:0] ERO_FLAGS    = 6'h04;
    localparam logic [5:0] ERO_MFG      = 6'h08;
    localparam logic [5:0] ERO_SERIAL   = 6'h0C;
    localparam logic [5:0] ERO_ROMVEC   = 6'h14;
    localparam logic [5:0] ERO_TBL_END  = 6'h18;
    localparam logic [5:0] ERO_INT_HI   = 6'h20;
    localparam logic [5:0] ERO_INT_LO   = 6'h21;
    localparam logic [5:0] ERO_BASE_HI  = 6'h24;
    localparam logic [5:0] ERO_BASE_LO  = 6'h25;
    localparam logic [5:0] ERO_SHUTUP   = 6'h26;
    localparam logic [7:0] ERT_ZORROII        = 8'hC0;
    localparam logic [7:0] ERTF_MEMLIST       = 8'h20;
    localparam logic [7:0] ERTF_DIAGVALID     = 8'h10;
    localparam logic [7:0] ERTF_CHAINEDCONFIG = 8'h08;
    localparam logic [2:0] ERT_SIZE_8M   = 3'b000;
    localparam logic [2:0] ERT_SIZE_64K  = 3'b001;
    localparam logic [2:0] ERT_SIZE_128K = 3'b010;
    localparam logic [2:0] ERT_SIZE_256K = 3'b011;
    localparam logic [2:0] ERT_SIZE_512K = 3'b100;
    localparam logic [2:0] ERT_SIZE_1M   = 3'b101;
    localparam logic [2:0] ERT_SIZE_2M   = 3'b110;
    localparam logic [2:0] ERT_SIZE_4M   = 3'b111;
    typedef enum logic [1:0] {CFG_IDLE, CFG_PEND, CFG_DONE} cfg_state_e;
endpackage

// File: rtl/autoconfig_er_rom.sv
// autoconfig_er_rom: expansion ROM nibble lookup for the board selected by idx
module autoconfig_er_rom
    import autoconfig_pkg::*;
#(
    parameter int NUM_CARDS = 2,
    parameter logic [15:0] MFG_ID = 16'h082C,
    parameter logic [31:0] SERIAL = 32'h0,
    parameter logic [8*NUM_CARDS-1:0] ER_TYPE = {NUM_CARDS{8'hE0}},
    parameter logic [8*NUM_CARDS-1:0] PROD_ID = {NUM_CARDS{8'h00}},
    parameter logic [8*NUM_CARDS-1:0] ER_FLAGS = {NUM_CARDS{8'hC0}},
    parameter logic [16*NUM_CARDS-1:0] ROM_VEC = {NUM_CARDS{16'h0}}
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [5:0]       a_low,
    output logic [3:0]       d
);
    logic [7:0] er_type, prod_id, er_flags;
    logic [15:0] rom_vec;
    logic [95:0] tbl;
    always_comb begin
        er_type = ER_TYPE[7:0];
        prod_id = PROD_ID[7:0];
        er_flags = ER_FLAGS[7:0];
        rom_vec = ROM_VEC[15:0];
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (idx == IDX_W'(i)) begin
                er_type = ER_TYPE[8*i +: 8];
                prod_id = PROD_ID[8*i +: 8];
                er_flags = ER_FLAGS[8*i +: 8];
                rom_vec = ROM_VEC[16*i +: 16];
            end
        end
        // Offsets 00..2E as one nibble stream, msb first; 0C/0E are reserved and read F
        tbl = {er_type, ~prod_id, ~er_flags, 8'hFF, ~MFG_ID, ~SERIAL, ~rom_vec};
        d = a_low < ERO_TBL_END ? 4'(tbl >> (7'd92 - {a_low[4:0], 2'b00})) :
            (a_low == ERO_INT_HI || a_low == ERO_INT_LO) ? 4'h0 : 4'hF;
    end
endmodule

// File: rtl/autoconfig_zii_chain.sv
// autoconfig_zii_chain: Zorro II AutoConfig responder presenting NUM_CARDS boards in turn behind one slot
module autoconfig_zii_chain
    import autoconfig_pkg::*;
#(
    parameter int NUM_CARDS = 2,
    parameter logic [15:0] MFG_ID = 16'h082C,
    parameter logic [31:0] SERIAL = 32'h0,
    parameter logic [8*NUM_CARDS-1:0] ER_TYPE = {NUM_CARDS{8'hE0}},
    parameter logic [8*NUM_CARDS-1:0] PROD_ID = {NUM_CARDS{8'h00}},
    parameter logic [8*NUM_CARDS-1:0] ER_FLAGS = {NUM_CARDS{8'hC0}},
    parameter logic [16*NUM_CARDS-1:0] ROM_VEC = {NUM_CARDS{16'h0}}
) (
    input  logic                   C7M,
    input  logic                   RESET_n,
    input  logic                   CFGIN_n,
    input  logic                   AS_n,
    input  logic                   DS_n,
    input  logic                   RW_n,
    input  logic [7:0]             A_HIGH,
    input  logic [5:0]             A_LOW,
    input  logic [3:0]             D_IN,
    output logic [3:0]             D_OUT,
    output logic                   D_OE,
    output logic [8*NUM_CARDS-1:0] BASE,
    output logic [NUM_CARDS-1:0]   CONFIGURED_n,
    output logic [NUM_CARDS-1:0]   SHUTUP_n,
    output logic                   CFGOUT_n
);
    cfg_state_e state;
    logic [IDX_W-1:0] idx;
    logic [2:0] as_s, ds_s;
    logic pend_cfg, pend_shut, access, wr_stb, as_rise, last;
    logic [3:0] rom_d;

    autoconfig_er_rom #(
        .NUM_CARDS(NUM_CARDS), .MFG_ID(MFG_ID), .SERIAL(SERIAL), .ER_TYPE(ER_TYPE),
        .PROD_ID(PROD_ID), .ER_FLAGS(ER_FLAGS), .ROM_VEC(ROM_VEC)
    ) u_rom (.idx(idx), .a_low(A_LOW), .d(rom_d));

    assign access = !CFGIN_n && CFGOUT_n && A_HIGH == ER_BOARD_PAGE && !AS_n;
    assign D_OE = access && RW_n && !DS_n;
    assign D_OUT = D_OE ? rom_d : 4'hF;
    assign wr_stb = ds_s[2] && !ds_s[1] && access && !RW_n;
    assign as_rise = !as_s[2] && as_s[1];
    assign last = idx == IDX_W'(NUM_CARDS - 1);

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= CFG_IDLE;
            idx <= '0;
            as_s <= '1;
            ds_s <= '1;
            pend_cfg <= 1'b0;
            pend_shut <= 1'b0;
            BASE <= '0;
            CONFIGURED_n <= '1;
            SHUTUP_n <= '1;
            CFGOUT_n <= 1'b1;
        end else begin
            as_s <= {as_s[1:0], AS_n};
            ds_s <= {ds_s[1:0], DS_n};
            if (state == CFG_PEND && as_rise && !CFGIN_n) begin
                // Configure takes priority when both base and shut-up were written
                for (int i = 0; i < NUM_CARDS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        CONFIGURED_n[i] <= !pend_cfg;
                        SHUTUP_n[i] <= pend_cfg || !pend_shut;
                    end
                end
                idx <= idx + 1'b1;
                pend_cfg <= 1'b0;
                pend_shut <= 1'b0;
                state <= last ? CFG_DONE : CFG_IDLE;
                CFGOUT_n <= !last;
            end else if (wr_stb) begin
                for (int i = 0; i < NUM_CARDS; i++) begin
                    if (idx == IDX_W'(i) && A_LOW == ERO_BASE_HI) BASE[8*i+4 +: 4] <= D_IN;
                    if (idx == IDX_W'(i) && A_LOW == ERO_BASE_LO) BASE[8*i +: 4] <= D_IN;
                end
                if (A_LOW == ERO_BASE_HI) pend_cfg <= 1'b1;
                if (A_LOW == ERO_SHUTUP) pend_shut <= 1'b1;
                if (A_LOW == ERO_BASE_HI || A_LOW == ERO_SHUTUP) state <= CFG_PEND;
            end
        end
    end
endmodule

// File: tb/tb_autoconfig_zii_chain.sv
// tb_autoconfig_zii_chain: directed bus-cycle bench for the two-board AutoConfig chain
module tb_autoconfig_zii_chain;
    logic C7M = 1'b0, RESET_n = 1'b0, CFGIN_n = 1'b0, AS_n = 1'b1, DS_n = 1'b1, RW_n = 1'b1;
    logic [7:0] A_HIGH = 8'h00;
    logic [5:0] A_LOW = 6'h00;
    logic [3:0] D_IN = 4'h0;
    logic [3:0] D_OUT;
    logic D_OE, CFGOUT_n;
    logic [15:0] BASE;
    logic [1:0] CONFIGURED_n, SHUTUP_n;
    int n_cmp = 0, n_err = 0;

    autoconfig_zii_chain #(
        .NUM_CARDS(2), .MFG_ID(16'h082C), .SERIAL(32'h12345678),
        .ER_TYPE({8'hC1, 8'hE0}), .PROD_ID({8'h3C, 8'h5A}), .ER_FLAGS({8'h80, 8'hC0}),
        .ROM_VEC({16'h0000, 16'h1234})
    ) dut (
        .C7M(C7M), .RESET_n(RESET_n), .CFGIN_n(CFGIN_n), .AS_n(AS_n), .DS_n(DS_n), .RW_n(RW_n),
        .A_HIGH(A_HIGH), .A_LOW(A_LOW), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .BASE(BASE),
        .CONFIGURED_n(CONFIGURED_n), .SHUTUP_n(SHUTUP_n), .CFGOUT_n(CFGOUT_n)
    );

    always #5 C7M = ~C7M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [3:0] exp_d, input logic exp_oe);
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = a; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
        #2;
        check({tag, "_oe"}, 32'(D_OE), 32'(exp_oe));
        check(tag, 32'(D_OUT), 32'(exp_d));
        @(negedge C7M);
        AS_n = 1'b1; DS_n = 1'b1; A_HIGH = 8'h00;
        repeat (4) @(negedge C7M);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] d, input int hold);
        @(negedge C7M);
        A_HIGH = 8'hE8; A_LOW = a; RW_n = 1'b0; D_IN = d; AS_n = 1'b0; DS_n = 1'b0;
        repeat (hold) @(negedge C7M);
        AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1; A_HIGH = 8'h00;
        repeat (5) @(negedge C7M);
    endtask

    initial begin
        repeat (3) @(negedge C7M);
        check("rst_oe", 32'(D_OE), 32'h0);
        check("rst_dout", 32'(D_OUT), 32'hF);
        check("rst_base", 32'(BASE), 32'h0);
        check("rst_cfg", 32'(CONFIGURED_n), 32'h3);
        check("rst_shut", 32'(SHUTUP_n), 32'h3);
        check("rst_cfgout", 32'(CFGOUT_n), 32'h1);
        RESET_n = 1'b1;
        repeat (2) @(negedge C7M);
        rd("b0_00", 6'h00, 4'hE, 1'b1);
        rd("b0_02", 6'h01, 4'h0, 1'b1);
        rd("b0_04", 6'h02, 4'hA, 1'b1);
        rd("b0_06", 6'h03, 4'h5, 1'b1);
        rd("b0_08", 6'h04, 4'h3, 1'b1);
        rd("b0_0a", 6'h05, 4'hF, 1'b1);
        rd("b0_0c", 6'h06, 4'hF, 1'b1);
        rd("b0_10", 6'h08, 4'hF, 1'b1);
        rd("b0_12", 6'h09, 4'h7, 1'b1);
        rd("b0_14", 6'h0A, 4'hD, 1'b1);
        rd("b0_16", 6'h0B, 4'h3, 1'b1);
        rd("b0_18", 6'h0C, 4'hE, 1'b1);
        rd("b0_26", 6'h13, 4'h7, 1'b1);
        rd("b0_28", 6'h14, 4'hE, 1'b1);
        rd("b0_3e", 6'h1F, 4'hF, 1'b1);
        rd("b0_40", 6'h20, 4'h0, 1'b1);
        rd("b0_42", 6'h21, 4'h0, 1'b1);
        wr(6'h25, 4'h4, 4);
        check("part_base", 32'(BASE), 32'h0004);
        check("part_cfg", 32'(CONFIGURED_n), 32'h3);
        @(negedge C7M);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_base", 32'(BASE), 32'h0);
        @(negedge C7M);
        RESET_n = 1'b1;
        repeat (2) @(negedge C7M);
        check("mid_rst_cfgout", 32'(CFGOUT_n), 32'h1);
        rd("mid_rst_idx", 6'h00, 4'hE, 1'b1);
        wr(6'h25, 4'h0, 4);
        wr(6'h24, 4'h2, 10);
        check("cfg_base", 32'(BASE), 32'h0020);
        check("cfg_cfg", 32'(CONFIGURED_n), 32'h2);
        check("cfg_shut", 32'(SHUTUP_n), 32'h3);
        check("cfg_cfgout", 32'(CFGOUT_n), 32'h1);
        rd("b1_00", 6'h00, 4'hC, 1'b1);
        rd("b1_02", 6'h01, 4'h1, 1'b1);
        rd("b1_04", 6'h02, 4'hC, 1'b1);
        rd("b1_08", 6'h04, 4'h7, 1'b1);
        CFGIN_n = 1'b1;
        rd("cfgin_rd", 6'h00, 4'hF, 1'b0);
        wr(6'h26, 4'h0, 4);
        check("cfgin_shut", 32'(SHUTUP_n), 32'h3);
        check("cfgin_cfg", 32'(CONFIGURED_n), 32'h2);
        check("cfgin_cfgout", 32'(CFGOUT_n), 32'h1);
        CFGIN_n = 1'b0;
        rd("cfgin_back", 6'h00, 4'hC, 1'b1);
        wr(6'h26, 4'h0, 4);
        check("shut_shut", 32'(SHUTUP_n), 32'h1);
        check("shut_cfg", 32'(CONFIGURED_n), 32'h2);
        check("shut_cfgout", 32'(CFGOUT_n), 32'h0);
        check("shut_base", 32'(BASE), 32'h0020);
        rd("done_rd", 6'h00, 4'hF, 1'b0);
        wr(6'h24, 4'h7, 4);
        check("done_base", 32'(BASE), 32'h0020);
        check("done_cfg", 32'(CONFIGURED_n), 32'h2);
        check("done_shut", 32'(SHUTUP_n), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
